// File: rtl/bam_rx.sv
// bam_rx: bit-angle-modulation (BAM) line decoder.
// Samples the BAM line once per cycle and rebuilds the duty word. Bit k owns
// line positions [2^k, 2^(k+1)), and its value is taken in the last cycle of
// that slot. Each frame is 2^NO_BITS+1 cycles long.
// Optional slot-consistency checker: define BAM_RX_ERR_EN to compile it in.
// Without that macro, err is tied low.
module bam_rx #(
  parameter int unsigned NO_BITS = 16
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               go,
  input  logic               in,
  output logic [NO_BITS-1:0] duty,
  output logic               valid,
  output logic               err
);

  localparam int unsigned     CW       = NO_BITS + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(2 ** NO_BITS);

  logic [CW-1:0]      cnt;
  logic [NO_BITS-2:0] shadow;
  logic [NO_BITS-2:0] shadow_nxt;
  logic               at_last;

  // Frame decode: last counter value, and where each lower bit is captured.
  always_comb begin
    at_last    = (cnt == CNT_LAST);
    shadow_nxt = shadow;
    for (int k = 0; k < int'(NO_BITS) - 1; k++) begin
      if (cnt == CW'(2 ** (k + 1))) shadow_nxt[k] = in;
    end
  end

  // Frame counter, shadow word and duty delivery.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      shadow <= '0;
      duty   <= '0;
      valid  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!go) begin
        cnt    <= '0;
        shadow <= '0;
      end else begin
        if (at_last) begin
          cnt   <= '0;
          duty  <= {in, shadow};
          valid <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
        if (cnt == '0) shadow <= '0;
        else           shadow <= shadow_nxt;
      end
    end
  end

`ifdef BAM_RX_ERR_EN
  logic [CW-1:0] pos;
  logic          slot_start;
  logic          slot_later;
  logic          mism;
  logic          ref_bit;
  logic          flag;

  // A slot starts where the line position is a power of two. Every later
  // cycle in the same slot must repeat that first sample.
  always_comb begin
    pos        = cnt - CW'(1);
    slot_start = (cnt >= CW'(2)) && ((pos & (pos - CW'(1))) == '0);
    slot_later = (cnt >= CW'(3)) && !slot_start;
    mism       = slot_later && (in != ref_bit);
  end

  // The sticky per-frame flag is delivered on err together with valid.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      ref_bit <= 1'b0;
      flag    <= 1'b0;
      err     <= 1'b0;
    end else if (!go || cnt == '0) begin
      flag <= 1'b0;
    end else begin
      if (slot_start) ref_bit <= in;
      if (at_last) begin
        err  <= flag | mism;
        flag <= 1'b0;
      end else begin
        flag <= flag | mism;
      end
    end
  end
`else
  // No checker compiled in.
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bam_rx.sv
// tb_bam_rx: directed scoreboard bench for bam_rx with NO_BITS=4.
// A model BAM encoder drives the line. Expected deliveries are queued, and
// a monitor pops one entry for each valid pulse it sees.
module tb_bam_rx;

  localparam int unsigned N = 4;

`ifdef BAM_RX_ERR_EN
  localparam logic GLITCH_ERR = 1'b1;
`else
  localparam logic GLITCH_ERR = 1'b0;
`endif

  typedef struct {
    logic [N-1:0] duty;
    logic         err;
    int           gap;   // required cycles since previous valid, 0 = unchecked
  } exp_t;

  logic         clock = 1'b0;
  logic         rst_n = 1'b0;
  logic         go    = 1'b0;
  logic         in    = 1'b0;
  logic [N-1:0] duty;
  logic         valid;
  logic         err;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   last_cyc = 0;

  bam_rx #(.NO_BITS(N)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .go    (go),
    .in    (in),
    .duty  (duty),
    .valid (valid),
    .err   (err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  // Line value while the receiver counter equals c.
  function automatic logic line_val(input logic [N-1:0] d, input int c, input int gp);
    int   p;
    int   k;
    logic b;
    if (c < 2) return 1'b0;
    p = c - 1;
    k = 0;
    for (int j = 0; j < int'(N); j++) if (p >= (1 << j)) k = j;
    b = d[k];
    if (p == gp) b = ~b;
    return b;
  endfunction

  // Drive one frame. If abort_at is reached, go drops at that counter value.
  task automatic drive_frame(input logic [N-1:0] d, input int gp, input int abort_at);
    for (int c = 0; c <= (1 << N); c++) begin
      @(negedge clock);
      if (c == abort_at) begin
        go = 1'b0;
        in = 1'b0;
        return;
      end
      go = 1'b1;
      in = line_val(d, c, gp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      go = 1'b0;
      in = 1'b0;
    end
  endtask

  task automatic expect_frame(input logic [N-1:0] d, input logic e, input int gap);
    exp_t x;
    x.duty = d;
    x.err  = e;
    x.gap  = gap;
    q.push_back(x);
  endtask

  // Monitor: every valid pulse must match the oldest queued delivery.
  always @(negedge clock) begin
    exp_t x;
    if (rst_n && valid) begin
      if (q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_valid: duty=%0h err=%0b with no delivery queued (t=%0t)",
                 duty, err, $time);
      end else begin
        x = q.pop_front();
        check("duty", int'(duty), int'(x.duty));
        check("err", int'(err), int'(x.err));
        if (x.gap != 0) check("valid_gap", cyc - last_cyc, x.gap);
      end
      last_cyc = cyc;
    end
  end

  initial begin
    int waited;
    // Reset values.
    repeat (3) @(negedge clock);
    check("rst_duty", int'(duty), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_err", int'(err), 0);
    rst_n = 1'b1;
    idle(2);

    // Loopback duty 0..15, back-to-back frames.
    for (int v = 0; v < 16; v++) begin
      expect_frame(N'(v), 1'b0, (v == 0) ? 0 : 17);
      drive_frame(N'(v), -1, -1);
    end
    idle(3);

    // Single-cycle glitch in the middle of the bit-3 slot.
    expect_frame(4'b1010, GLITCH_ERR, 0);
    drive_frame(4'b1010, 11, -1);
    idle(3);

    // Back-to-back edge values.
    expect_frame(4'b0000, 1'b0, 0);
    drive_frame(4'b0000, -1, -1);
    expect_frame(4'b1111, 1'b0, 17);
    drive_frame(4'b1111, -1, -1);
    idle(3);

    // Abort at cnt=5: no delivery, duty held.
    drive_frame(4'b0101, -1, 5);
    idle(20);
    check("abort_duty_hold", int'(duty), 4'hF);
    check("abort_err_hold", int'(err), 0);
    expect_frame(4'b0110, 1'b0, 0);
    drive_frame(4'b0110, -1, -1);
    idle(3);

    // Reset asserted at cnt=9 in the middle of a frame.
    for (int c = 0; c < 9; c++) begin
      @(negedge clock);
      go = 1'b1;
      in = line_val(4'b1100, c, -1);
    end
    @(negedge clock);
    rst_n = 1'b0;
    go    = 1'b0;
    in    = 1'b0;
    #1;
    check("midrst_duty", int'(duty), 0);
    check("midrst_valid", int'(valid), 0);
    check("midrst_err", int'(err), 0);
    idle(2);
    @(negedge clock);
    rst_n = 1'b1;
    idle(2);
    expect_frame(4'b1001, 1'b0, 0);
    drive_frame(4'b1001, -1, -1);
    idle(3);

    // Every queued delivery must have arrived (bounded wait).
    waited = 0;
    while (q.size() != 0 && waited < 100) begin
      @(negedge clock);
      waited++;
    end
    check("queue_drain", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
